// File: rtl/gsim_pkg.sv
// rtl/gsim_pkg.sv - shared constants and state encoding for the GSIM sequencing controller
package gsim_pkg;

  localparam int N_ROW        = 16;
  localparam int ROW_W        = 4;
  localparam int ITER_W       = 8;
  localparam int DEF_MAX_ITER = 200;
  localparam int DEF_MIN_ITER = 2;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ISSUE,
    S_WAIT,
    S_SWEEP_END,
    S_READ
  } state_t;

endpackage

// File: rtl/gsim_seq_ctrl.sv
// rtl/gsim_seq_ctrl.sv - Gauss-Seidel sweep sequencer: b load, per-row issue/ack, convergence stop, x readout
module gsim_seq_ctrl
  import gsim_pkg::*;
#(
  parameter int MAX_ITER = DEF_MAX_ITER,
  parameter int MIN_ITER = DEF_MIN_ITER
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_en,
  output logic              b_we,
  output logic [ROW_W-1:0]  b_waddr,
  output logic              row_req,
  output logic [ROW_W-1:0]  row_idx,
  output logic              first_sweep,
  input  logic              row_ack,
  input  logic              row_conv,
  output logic              x_rd_en,
  output logic [ROW_W-1:0]  x_rd_addr,
  output logic              out_valid,
  output logic              busy,
  output logic [ITER_W-1:0] iter_cnt
);

  state_t             state;
  logic [ROW_W-1:0]   cnt;
  logic               sweep_conv;
  logic [ITER_W-1:0]  iter_next;
  logic               stop_iter;

  assign iter_next = iter_cnt + 1'b1;
  assign stop_iter = ((iter_next >= ITER_W'(MIN_ITER)) && sweep_conv)
                   || (iter_next == ITER_W'(MAX_ITER));

  // One shared counter serves as load address, row index and read address.
  assign b_we        = in_en && (state == S_IDLE || state == S_LOAD);
  assign b_waddr     = cnt;
  assign row_req     = (state == S_ISSUE);
  assign row_idx     = cnt;
  assign first_sweep = (iter_cnt == '0) && (state == S_ISSUE || state == S_WAIT);
  assign x_rd_en     = (state == S_READ);
  assign x_rd_addr   = cnt;
  // The final readout word leaves one cycle after READ, so busy covers it.
  assign busy        = (state != S_IDLE) || out_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      iter_cnt   <= '0;
      sweep_conv <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= (state == S_READ);
      case (state)
        S_IDLE: begin
          if (in_en) begin
            cnt   <= ROW_W'(1);
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (in_en) begin
            if (cnt == LAST_ROW) begin
              cnt        <= '0;
              iter_cnt   <= '0;
              sweep_conv <= 1'b1;
              state      <= S_ISSUE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (row_ack) begin
            sweep_conv <= sweep_conv & row_conv;
            if (cnt == LAST_ROW) begin
              state <= S_SWEEP_END;
            end else begin
              cnt   <= cnt + 1'b1;
              state <= S_ISSUE;
            end
          end
        end
        S_SWEEP_END: begin
          iter_cnt <= iter_next;
          cnt      <= '0;
          if (stop_iter) begin
            state <= S_READ;
          end else begin
            sweep_conv <= 1'b1;
            state      <= S_ISSUE;
          end
        end
        S_READ: begin
          if (cnt == LAST_ROW) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gsim_seq_ctrl.sv
// tb/tb_gsim_seq_ctrl.sv - directed bench for gsim_seq_ctrl (default instance plus MAX_ITER=5 instance)
module tb_gsim_seq_ctrl;
  import gsim_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic              in_en = 1'b0;
  logic              row_ack = 1'b0;
  logic              row_conv = 1'b0;
  logic              b_we, row_req, first_sweep, x_rd_en, out_valid, busy;
  logic [ROW_W-1:0]  b_waddr, row_idx, x_rd_addr;
  logic [ITER_W-1:0] iter_cnt;

  logic              in_en5 = 1'b0;
  logic              row_ack5 = 1'b0;
  logic              row_conv5 = 1'b0;
  logic              b_we5, row_req5, first_sweep5, x_rd_en5, out_valid5, busy5;
  logic [ROW_W-1:0]  b_waddr5, row_idx5, x_rd_addr5;
  logic [ITER_W-1:0] iter_cnt5;

  gsim_seq_ctrl u_dut (
    .clk(clk), .reset(reset), .in_en(in_en), .b_we(b_we), .b_waddr(b_waddr),
    .row_req(row_req), .row_idx(row_idx), .first_sweep(first_sweep),
    .row_ack(row_ack), .row_conv(row_conv), .x_rd_en(x_rd_en), .x_rd_addr(x_rd_addr),
    .out_valid(out_valid), .busy(busy), .iter_cnt(iter_cnt)
  );

  gsim_seq_ctrl #(.MAX_ITER(5), .MIN_ITER(2)) u_dut5 (
    .clk(clk), .reset(reset), .in_en(in_en5), .b_we(b_we5), .b_waddr(b_waddr5),
    .row_req(row_req5), .row_idx(row_idx5), .first_sweep(first_sweep5),
    .row_ack(row_ack5), .row_conv(row_conv5), .x_rd_en(x_rd_en5), .x_rd_addr(x_rd_addr5),
    .out_valid(out_valid5), .busy(busy5), .iter_cnt(iter_cnt5)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int conv_from = 0;

  // Row-update model: ack one cycle after each req; row_conv once sweep >= conv_from.
  int   acks = 0;
  logic req_d = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      acks = 0; row_ack = 1'b0; row_conv = 1'b0; req_d = 1'b0;
    end else begin
      row_ack  = req_d;
      row_conv = 1'b0;
      if (req_d) begin
        row_conv = ((acks / N_ROW) >= conv_from);
        acks++;
      end
      req_d = row_req;
    end
  end

  logic req5_d = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      row_ack5 = 1'b0; row_conv5 = 1'b0; req5_d = 1'b0;
    end else begin
      row_ack5  = req5_d;
      row_conv5 = 1'b0;
      req5_d    = row_req5;
    end
  end

  int   req_cnt, fs_req_cnt, fs_cyc, we_cnt, addr_err, idx_err, rd_err;
  int   ov_cnt, ov_run, ov_max, rd_cnt, req5_cnt, ov5_cnt;
  logic last_ov_busy;
  always @(negedge clk) begin
    if (reset) begin
      req_cnt = 0; fs_req_cnt = 0; fs_cyc = 0; we_cnt = 0; addr_err = 0; idx_err = 0;
      rd_err = 0; ov_cnt = 0; ov_run = 0; ov_max = 0; rd_cnt = 0; req5_cnt = 0; ov5_cnt = 0;
      last_ov_busy = 1'b0;
    end else begin
      if (row_req) begin
        if (row_idx != ROW_W'(req_cnt % N_ROW)) idx_err++;
        req_cnt++;
        if (first_sweep) fs_req_cnt++;
      end
      if (first_sweep) fs_cyc++;
      if (b_we) begin
        if (b_waddr != ROW_W'(we_cnt % N_ROW)) addr_err++;
        we_cnt++;
      end
      if (x_rd_en) begin
        if (x_rd_addr != ROW_W'(rd_cnt % N_ROW)) rd_err++;
        rd_cnt++;
      end
      if (out_valid) begin
        ov_cnt++; ov_run++;
        if (ov_run > ov_max) ov_max = ov_run;
      end else begin
        ov_run = 0;
      end
      if (busy) last_ov_busy = out_valid;
      if (row_req5) req5_cnt++;
      if (out_valid5) ov5_cnt++;
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1; in_en = 1'b0; in_en5 = 1'b0;
    @(posedge clk); @(posedge clk); #1 reset = 1'b0;
  endtask

  task automatic load(input int gap);
    for (int i = 0; i < N_ROW; i++) begin
      @(posedge clk); #1 in_en = 1'b1;
      @(negedge clk);
      check("load_b_we", b_we, 1);
      check("load_b_waddr", b_waddr, i);
      check("load_no_req", row_req, 0);
      if (i < N_ROW - 1) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1 in_en = 1'b0;
          @(negedge clk);
          check("gap_no_we", b_we, 0);
        end
      end
    end
    @(posedge clk); #1 in_en = 1'b0;
    @(negedge clk);
    check("issue_req", row_req, 1);
    check("issue_row0", row_idx, 0);
    check("issue_first_sweep", first_sweep, 1);
    @(negedge clk);
    check("req_one_cycle", row_req, 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk); n++;
    end
    #1;
    check("idle_within_budget", busy, 0);
  endtask

  initial begin
    // Reset state
    do_reset();
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_row_req", row_req, 0);
    check("rst_b_we", b_we, 0);
    check("rst_x_rd_en", x_rd_en, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_iter_cnt", iter_cnt, 0);
    check("rst_row_idx", row_idx, 0);
    check("rst_busy5", busy5, 0);

    // 1: contiguous load, converge at MIN_ITER
    conv_from = 0;
    do_reset();
    load(0);
    wait_idle(2000);
    check("t1_we_cnt", we_cnt, 16);
    check("t1_addr_err", addr_err, 0);
    check("t1_req_cnt", req_cnt, 32);
    check("t1_iter_cnt", iter_cnt, 2);
    check("t1_ov_cnt", ov_cnt, 16);

    // 2: gapped load, in_en held during solve is ignored
    conv_from = 0;
    do_reset();
    load(1);
    @(posedge clk); #1 in_en = 1'b1;
    repeat (10) @(posedge clk);
    #1 in_en = 1'b0;
    wait_idle(2000);
    check("t2_we_cnt", we_cnt, 16);
    check("t2_addr_err", addr_err, 0);
    check("t2_iter_cnt", iter_cnt, 2);

    // 3: convergence only in sweep 3
    conv_from = 3;
    do_reset();
    load(0);
    wait_idle(4000);
    check("t3_req_cnt", req_cnt, 64);
    check("t3_idx_err", idx_err, 0);
    check("t3_iter_cnt", iter_cnt, 4);
    check("t3_ov_cnt", ov_cnt, 16);
    check("t3_ov_burst", ov_max, 16);
    check("t3_rd_err", rd_err, 0);
    check("t3_busy_last_ov", last_ov_busy, 1);

    // 4: never converges, capped at MAX_ITER=5
    do_reset();
    for (int i = 0; i < N_ROW; i++) begin
      @(posedge clk); #1 in_en5 = 1'b1;
    end
    @(posedge clk); #1 in_en5 = 1'b0;
    begin
      int n = 0;
      while (busy5 && n < 4000) begin
        @(negedge clk); n++;
      end
      #1;
      check("t4_idle_within_budget", busy5, 0);
    end
    check("t4_req5_cnt", req5_cnt, 80);
    check("t4_iter_cnt5", iter_cnt5, 5);
    check("t4_ov5_cnt", ov5_cnt, 16);

    // 5: converges immediately, first_sweep only on first 16 rows
    conv_from = 0;
    do_reset();
    load(0);
    wait_idle(2000);
    check("t5_req_cnt", req_cnt, 32);
    check("t5_iter_cnt", iter_cnt, 2);
    check("t5_fs_req", fs_req_cnt, 16);
    check("t5_fs_cycles", fs_cyc, 32);

    // 6: reset during WAIT of sweep 1, then a fresh solve
    conv_from = 1000;
    do_reset();
    load(0);
    begin
      int n = 0;
      while (!(row_req && iter_cnt == 1) && n < 500) begin
        @(negedge clk); n++;
      end
      check("t6_reach_sweep1", n < 500, 1);
    end
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("t6_in_wait", row_req, 0);
    @(negedge clk);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_row_req", row_req, 0);
    check("t6_rst_first_sweep", first_sweep, 0);
    check("t6_rst_iter_cnt", iter_cnt, 0);
    check("t6_rst_x_rd_en", x_rd_en, 0);
    #1 reset = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("t6_no_out_valid", ov_cnt, 0);
    check("t6_still_idle", busy, 0);
    conv_from = 0;
    load(0);
    wait_idle(2000);
    check("t6_fresh_ov_cnt", ov_cnt, 16);
    check("t6_fresh_iter_cnt", iter_cnt, 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
